can_mc_bus_slave: RTL and testbench

//  Parametrised microcontroller bus slave for the CAN controller. It replaces the free-running read/write

---
 rtl/can_mc_pkg.sv | 16 +
 rtl/can_addr_onehot_dec.sv | 24 ++
 rtl/can_mc_bus_slave.sv | 130 +++++++++++++
 tb/tb_can_mc_bus_slave.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/can_mc_pkg.sv
// Shared types and default sizing for the CAN microcontroller bus slave.
package can_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mc_state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_NUM_REGS    = 31;
  localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/can_addr_onehot_dec.sv
// Register address decoder: one-hot select gated by en, plus an in-range flag.
module can_addr_onehot_dec #(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 31
) (
  input  logic [ADDR_W-1:0]   addr,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot,
  output logic                valid
);

  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NUM_REGS_V = (ADDR_W + 1)'(NUM_REGS);

  assign valid = ({1'b0, addr} < NUM_REGS_V);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (addr == ADDR_W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/can_mc_bus_slave.sv
// Single-transaction bus slave between the bus wrapper and the CAN config register file.
module can_mc_bus_slave
  import can_mc_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset,
  input  logic [DATA_W-1:0]     i_bus_data,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W/8-1:0]   i_byte_en,
  input  logic                  i_r_neg_w,
  input  logic                  i_cs,
  output logic [DATA_W-1:0]     o_reg_data,
  output logic                  o_ack,
  output logic                  o_error,
  output logic                  o_busy,
  input  logic [DATA_W-1:0]     i_reg_r_data,
  input  logic                  i_reg_ack,
  input  logic                  i_reg_error,
  output logic [DATA_W-1:0]     o_reg_w_bus,
  output logic [DATA_W/8-1:0]   o_reg_be,
  output logic [NUM_REGS-1:0]   o_rs_vector,
  output logic                  o_r_neg_w
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  mc_state_e         state_q, state_d;
  logic              cs_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              start, latch, load_rdata;
  logic [ADDR_W-1:0] dec_addr;
  logic              addr_valid;

  // In IDLE the live address is range-checked; afterwards the latched one drives the select.
  assign dec_addr = (state_q == IDLE) ? i_addr : addr_q;

  can_addr_onehot_dec #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .addr   (dec_addr),
    .en     (state_q == REQ),
    .onehot (o_rs_vector),
    .valid  (addr_valid)
  );

  assign start   = i_cs & ~cs_q & (state_q == IDLE);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    latch      = 1'b0;
    load_rdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          err_d   = ~addr_valid;
          state_d = addr_valid ? REQ : DONE;
        end
      end
      REQ: begin
        cnt_d = '0;
        if (i_reg_ack) begin
          err_d      = i_reg_error;
          load_rdata = o_r_neg_w & ~i_reg_error;
          state_d    = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_reg_ack) begin
          err_d      = i_reg_error;
          load_rdata = o_r_neg_w & ~i_reg_error;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      o_reg_w_bus <= '0;
      o_reg_be    <= '0;
      o_r_neg_w   <= 1'b0;
      o_reg_data  <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= i_cs;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        addr_q      <= i_addr;
        o_reg_w_bus <= i_bus_data;
        o_reg_be    <= i_r_neg_w ? '0 : i_byte_en;
        o_r_neg_w   <= i_r_neg_w;
      end
      if (load_rdata) o_reg_data <= i_reg_r_data;
    end
  end

  assign o_busy  = (state_q != IDLE);
  assign o_ack   = (state_q == DONE);
  assign o_error = o_ack & err_q;

endmodule

// File: tb/tb_can_mc_bus_slave.sv
// Randomized and directed bench for can_mc_bus_slave against a transaction-level model.
module tb_can_mc_bus_slave;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 31;
  localparam int T        = 16;
  localparam int BE_W     = DATA_W / 8;

  logic                i_sys_clk = 1'b0;
  logic                i_reset   = 1'b1;
  logic [DATA_W-1:0]   i_bus_data = '0;
  logic [ADDR_W-1:0]   i_addr = '0;
  logic [BE_W-1:0]     i_byte_en = '0;
  logic                i_r_neg_w = 1'b0;
  logic                i_cs = 1'b0;
  logic [DATA_W-1:0]   o_reg_data;
  logic                o_ack, o_error, o_busy;
  logic [DATA_W-1:0]   i_reg_r_data = '0;
  logic                i_reg_ack = 1'b0;
  logic                i_reg_error = 1'b0;
  logic [DATA_W-1:0]   o_reg_w_bus;
  logic [BE_W-1:0]     o_reg_be;
  logic [NUM_REGS-1:0] o_rs_vector;
  logic                o_r_neg_w;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] model_rdata = '0;

  always #5 i_sys_clk = ~i_sys_clk;

  can_mc_bus_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .TIMEOUT_CYC(T)
  ) dut (
    .i_sys_clk    (i_sys_clk),
    .i_reset      (i_reset),
    .i_bus_data   (i_bus_data),
    .i_addr       (i_addr),
    .i_byte_en    (i_byte_en),
    .i_r_neg_w    (i_r_neg_w),
    .i_cs         (i_cs),
    .o_reg_data   (o_reg_data),
    .o_ack        (o_ack),
    .o_error      (o_error),
    .o_busy       (o_busy),
    .i_reg_r_data (i_reg_r_data),
    .i_reg_ack    (i_reg_ack),
    .i_reg_error  (i_reg_error),
    .o_reg_w_bus  (o_reg_w_bus),
    .o_reg_be     (o_reg_be),
    .o_rs_vector  (o_rs_vector),
    .o_r_neg_w    (o_r_neg_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   64'(o_ack), 64'd0);
    check({tag, "_err"},   64'(o_error), 64'd0);
    check({tag, "_busy"},  64'(o_busy), 64'd0);
    check({tag, "_rs"},    64'(o_rs_vector), 64'd0);
    check({tag, "_wbus"},  64'(o_reg_w_bus), 64'd0);
    check({tag, "_be"},    64'(o_reg_be), 64'd0);
    check({tag, "_rnw"},   64'(o_r_neg_w), 64'd0);
    check({tag, "_rdata"}, 64'(o_reg_data), 64'd0);
  endtask

  // Cycle k counts negedges after the one where i_cs is raised. The model predicts
  // the cycle of o_ack from the address range, ack delay d (cycles after the select
  // cycle) and the timeout, then checks every output on every cycle of the transaction.
  task automatic run_txn(input string tag, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be,
                         input logic rnw, input int d, input logic rerr,
                         input logic [DATA_W-1:0] rdata, input bit glitch);
    bit valid, err, upd;
    int ack_cyc, last;
    logic [NUM_REGS-1:0] one, exp_rs;
    logic [DATA_W-1:0] exp_data;
    one   = 1;
    valid = (int'(addr) < NUM_REGS);
    if (!valid)        ack_cyc = 1;
    else if (d <= T-1) ack_cyc = 2 + d;
    else               ack_cyc = 1 + T;
    err  = !valid || (d > T-1) || rerr;
    upd  = rnw && !err;
    last = ack_cyc + 1;
    if (valid && (d + 2 > last)) last = d + 2;

    i_addr     = addr;
    i_bus_data = data;
    i_byte_en  = be;
    i_r_neg_w  = rnw;
    i_cs       = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge i_sys_clk);
      exp_rs   = (k == 1 && valid) ? (one << addr) : '0;
      exp_data = (upd && k >= ack_cyc) ? rdata : model_rdata;
      check({tag, "_rs"},    64'(o_rs_vector), 64'(exp_rs));
      check({tag, "_ack"},   64'(o_ack), 64'(k == ack_cyc));
      check({tag, "_err"},   64'(o_error), 64'(k == ack_cyc && err));
      check({tag, "_busy"},  64'(o_busy), 64'(k <= ack_cyc));
      check({tag, "_rdata"}, 64'(o_reg_data), 64'(exp_data));
      if (k <= ack_cyc) begin
        check({tag, "_wbus"}, 64'(o_reg_w_bus), 64'(data));
        check({tag, "_be"},   64'(o_reg_be), 64'(rnw ? '0 : be));
        check({tag, "_rnw"},  64'(o_r_neg_w), 64'(rnw));
      end
      i_cs         = glitch && (k == 3);
      i_addr       = ADDR_W'($urandom);
      i_bus_data   = DATA_W'($urandom);
      i_byte_en    = BE_W'($urandom);
      i_r_neg_w    = 1'($urandom);
      i_reg_ack    = valid && (k == 1 + d);
      i_reg_error  = i_reg_ack ? rerr : 1'($urandom);
      i_reg_r_data = i_reg_ack ? rdata : DATA_W'($urandom);
    end
    if (upd) model_rdata = rdata;
    i_reg_ack = 1'b0;
    i_cs      = 1'b0;
    @(negedge i_sys_clk);
    check({tag, "_idle"}, 64'(o_busy), 64'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    int rd;
    repeat (2) @(negedge i_sys_clk);
    check_all_zero("reset");
    i_reset = 1'b0;
    @(negedge i_sys_clk);

    run_txn("wr5",      6'd5,  32'hDEADBEEF, 4'b0011, 1'b0, 2, 1'b0, 32'h0, 1'b0);
    run_txn("rd0",      6'd0,  32'h0, 4'hF, 1'b1, 0, 1'b0, 32'h12345678, 1'b0);
    run_txn("rd40",     6'd40, 32'h0, 4'hF, 1'b1, 0, 1'b0, 32'hAAAA5555, 1'b0);
    run_txn("rd3_to",   6'd3,  32'h0, 4'hF, 1'b1, T + 2, 1'b0, 32'h0BADF00D, 1'b0);
    run_txn("rd_lastd", 6'd30, 32'h0, 4'h0, 1'b1, T - 1, 1'b0, 32'hCAFE0001, 1'b0);
    run_txn("rd_tod",   6'd30, 32'h0, 4'h0, 1'b1, T, 1'b0, 32'hCAFE0002, 1'b0);
    run_txn("glitch",   6'd7,  32'h0, 4'hF, 1'b1, 4, 1'b1, 32'h77777777, 1'b1);
    run_txn("wr_be0",   6'd9,  32'h01020304, 4'h0, 1'b0, 1, 1'b0, 32'h0, 1'b0);
    run_txn("rd63",     6'd63, 32'h0, 4'h0, 1'b1, 0, 1'b0, 32'h0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 4) == 0) ? ADDR_W'($urandom_range(NUM_REGS, 63))
                                       : ADDR_W'($urandom_range(0, NUM_REGS - 1));
      rd = int'($urandom_range(0, T + 3));
      run_txn("rand", ra, DATA_W'($urandom), BE_W'($urandom), 1'($urandom), rd,
              ($urandom_range(0, 3) == 0), DATA_W'($urandom),
              ($urandom_range(0, 3) == 0) && (int'(ra) < NUM_REGS) && (rd >= 1));
    end

    // Reset in the middle of a read wait: everything clears at once, no ack follows.
    i_addr = 6'd3; i_r_neg_w = 1'b1; i_cs = 1'b1;
    @(negedge i_sys_clk);
    i_cs = 1'b0;
    repeat (2) @(negedge i_sys_clk);
    check("rst_busy_before", 64'(o_busy), 64'd1);
    #2 i_reset = 1'b1;
    #1 check_all_zero("rst_mid");
    model_rdata = '0;
    repeat (2) begin
      @(negedge i_sys_clk);
      check("rst_hold_ack", 64'(o_ack), 64'd0);
    end
    i_reset = 1'b0;
    @(negedge i_sys_clk);
    run_txn("post_rst", 6'd12, 32'h0, 4'hF, 1'b1, 3, 1'b0, 32'h5A5A1234, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
